// File: rtl/dso100fb_video_pkg.sv
// Shared constants and segment-phase encoding for the dso100fb raster timing generator.
package dso100fb_video_pkg;

  localparam int CNT_W_DEF      = 12;
  localparam int UNDERRUN_CNT_W = 16;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } seg_phase_t;

endpackage

// File: rtl/dso100fb_timing_axis.sv
// Generic raster axis: position counter with active/fp/sync/bp segment decode.
// Used once per pixel for H and once per H wrap for V.
module dso100fb_timing_axis
  import dso100fb_video_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             VIDCLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] len_active,
  input  logic [CNT_W-1:0] len_fp,
  input  logic [CNT_W-1:0] len_sync,
  input  logic [CNT_W-1:0] len_bp,
  output logic [CNT_W+1:0] pos,
  output logic             wrap,
  output logic             seg_active,
  output logic             seg_sync
);

  // Two extra bits so the sum of four maximal segments cannot overflow.
  localparam int POS_W = CNT_W + 2;

  logic [POS_W-1:0] len_a, len_f, len_s, len_b;
  logic [POS_W-1:0] end_a, end_f, end_s, total_m1;
  logic             last;
  seg_phase_t       phase;

  function automatic logic [POS_W-1:0] seg_len(input logic [CNT_W-1:0] len);
    return (len == '0) ? POS_W'(1) : POS_W'(len);
  endfunction

  assign len_a    = seg_len(len_active);
  assign len_f    = seg_len(len_fp);
  assign len_s    = seg_len(len_sync);
  assign len_b    = seg_len(len_bp);
  assign end_a    = len_a;
  assign end_f    = end_a + len_f;
  assign end_s    = end_f + len_s;
  assign total_m1 = end_s + len_b - POS_W'(1);

  assign last = (pos == total_m1);
  assign wrap = inc && last;

  always_comb begin
    phase = PH_BP;
    if (pos < end_a)
      phase = PH_ACTIVE;
    else if (pos < end_f)
      phase = PH_FP;
    else if (pos < end_s)
      phase = PH_SYNC;
  end

  assign seg_active = (phase == PH_ACTIVE);
  assign seg_sync   = (phase == PH_SYNC);

  always_ff @(posedge VIDCLK) begin
    if (RST || clr)
      pos <= '0;
    else if (inc)
      pos <= last ? '0 : pos + POS_W'(1);
  end

endmodule

// File: rtl/dso100fb_video_timing.sv
// Raster sequencer for the framebuffer mixer: fetch/overlay pops one cycle ahead of DE/syncs.
// Define DSO100FB_UNDERRUN_COUNT_EN to build the saturating underrun cycle counter.
module dso100fb_video_timing
  import dso100fb_video_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                      VIDCLK,
  input  logic                      RST,
  input  logic                      CFG_ENABLE,
  input  logic [CNT_W-1:0]          CFG_HACTIVE,
  input  logic [CNT_W-1:0]          CFG_HFP,
  input  logic [CNT_W-1:0]          CFG_HSYNC,
  input  logic [CNT_W-1:0]          CFG_HBP,
  input  logic [CNT_W-1:0]          CFG_VACTIVE,
  input  logic [CNT_W-1:0]          CFG_VFP,
  input  logic [CNT_W-1:0]          CFG_VSYNC,
  input  logic [CNT_W-1:0]          CFG_VBP,
  input  logic                      CFG_HSYNC_POL,
  input  logic                      CFG_VSYNC_POL,
  input  logic                      CFG_OVL_ENABLE,
  input  logic [CNT_W-1:0]          CFG_OVL_X0,
  input  logic [CNT_W-1:0]          CFG_OVL_X1,
  input  logic [CNT_W-1:0]          CFG_OVL_Y0,
  input  logic [CNT_W-1:0]          CFG_OVL_Y1,
  input  logic                      VIDEO_EMPTY,
  input  logic                      UNDERRUN_CLR,
  output logic                      VIDEO_FETCH,
  output logic                      OVERLAY_EN,
  output logic                      DE,
  output logic                      HSYNC,
  output logic                      VSYNC,
  output logic                      FRAME_START,
  output logic                      UNDERRUN,
  output logic [UNDERRUN_CNT_W-1:0] UNDERRUN_COUNT
);

  localparam int POS_W = CNT_W + 2;

  logic [CNT_W-1:0] sh_hact, sh_hfp, sh_hsync, sh_hbp;
  logic [CNT_W-1:0] sh_vact, sh_vfp, sh_vsync, sh_vbp;
  logic [CNT_W-1:0] sh_x0, sh_x1, sh_y0, sh_y1;
  logic             sh_hpol, sh_vpol, sh_ovl_en;

  logic [POS_W-1:0] h_pos, v_pos;
  logic             h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
  logic             shadow_load, fetch_c, ovl_c, fs_c, in_x, in_y;
  logic             hs1, vs1, underrun_set;

  // v_wrap only fires together with h_wrap, so it marks the last pixel of the frame.
  assign shadow_load = !CFG_ENABLE || v_wrap;

  always_ff @(posedge VIDCLK) begin
    if (RST) begin
      sh_hact   <= '0;
      sh_hfp    <= '0;
      sh_hsync  <= '0;
      sh_hbp    <= '0;
      sh_vact   <= '0;
      sh_vfp    <= '0;
      sh_vsync  <= '0;
      sh_vbp    <= '0;
      sh_x0     <= '0;
      sh_x1     <= '0;
      sh_y0     <= '0;
      sh_y1     <= '0;
      sh_hpol   <= 1'b0;
      sh_vpol   <= 1'b0;
      sh_ovl_en <= 1'b0;
    end else if (shadow_load) begin
      sh_hact   <= CFG_HACTIVE;
      sh_hfp    <= CFG_HFP;
      sh_hsync  <= CFG_HSYNC;
      sh_hbp    <= CFG_HBP;
      sh_vact   <= CFG_VACTIVE;
      sh_vfp    <= CFG_VFP;
      sh_vsync  <= CFG_VSYNC;
      sh_vbp    <= CFG_VBP;
      sh_x0     <= CFG_OVL_X0;
      sh_x1     <= CFG_OVL_X1;
      sh_y0     <= CFG_OVL_Y0;
      sh_y1     <= CFG_OVL_Y1;
      sh_hpol   <= CFG_HSYNC_POL;
      sh_vpol   <= CFG_VSYNC_POL;
      sh_ovl_en <= CFG_OVL_ENABLE;
    end
  end

  dso100fb_timing_axis #(.CNT_W(CNT_W)) u_h_axis (
    .VIDCLK     (VIDCLK),
    .RST        (RST),
    .clr        (!CFG_ENABLE),
    .inc        (1'b1),
    .len_active (sh_hact),
    .len_fp     (sh_hfp),
    .len_sync   (sh_hsync),
    .len_bp     (sh_hbp),
    .pos        (h_pos),
    .wrap       (h_wrap),
    .seg_active (h_act),
    .seg_sync   (h_sync)
  );

  dso100fb_timing_axis #(.CNT_W(CNT_W)) u_v_axis (
    .VIDCLK     (VIDCLK),
    .RST        (RST),
    .clr        (!CFG_ENABLE),
    .inc        (h_wrap),
    .len_active (sh_vact),
    .len_fp     (sh_vfp),
    .len_sync   (sh_vsync),
    .len_bp     (sh_vbp),
    .pos        (v_pos),
    .wrap       (v_wrap),
    .seg_active (v_act),
    .seg_sync   (v_sync)
  );

  assign in_x    = (h_pos >= POS_W'(sh_x0)) && (h_pos < POS_W'(sh_x1));
  assign in_y    = (v_pos >= POS_W'(sh_y0)) && (v_pos < POS_W'(sh_y1));
  assign fetch_c = h_act && v_act;
  assign ovl_c   = fetch_c && sh_ovl_en && in_x && in_y;
  assign fs_c    = fetch_c && (h_pos == '0) && (v_pos == '0);

  // Stage 1 holds sync levels with polarity applied; stage 2 is a plain delay.
  always_ff @(posedge VIDCLK) begin
    if (RST) begin
      VIDEO_FETCH <= 1'b0;
      OVERLAY_EN  <= 1'b0;
      FRAME_START <= 1'b0;
      hs1         <= ~CFG_HSYNC_POL;
      vs1         <= ~CFG_VSYNC_POL;
      DE          <= 1'b0;
      HSYNC       <= ~CFG_HSYNC_POL;
      VSYNC       <= ~CFG_VSYNC_POL;
    end else begin
      DE    <= VIDEO_FETCH;
      HSYNC <= hs1;
      VSYNC <= vs1;
      if (CFG_ENABLE) begin
        VIDEO_FETCH <= fetch_c;
        OVERLAY_EN  <= ovl_c;
        FRAME_START <= fs_c;
        hs1         <= h_sync ? sh_hpol : ~sh_hpol;
        vs1         <= v_sync ? sh_vpol : ~sh_vpol;
      end else begin
        VIDEO_FETCH <= 1'b0;
        OVERLAY_EN  <= 1'b0;
        FRAME_START <= 1'b0;
        hs1         <= ~CFG_HSYNC_POL;
        vs1         <= ~CFG_VSYNC_POL;
      end
    end
  end

  assign underrun_set = VIDEO_FETCH && VIDEO_EMPTY;

  always_ff @(posedge VIDCLK) begin
    if (RST)
      UNDERRUN <= 1'b0;
    else if (underrun_set)
      UNDERRUN <= 1'b1;
    else if (UNDERRUN_CLR)
      UNDERRUN <= 1'b0;
  end

`ifdef DSO100FB_UNDERRUN_COUNT_EN
  logic [UNDERRUN_CNT_W-1:0] urun_cnt;

  always_ff @(posedge VIDCLK) begin
    if (RST)
      urun_cnt <= '0;
    else if (underrun_set) begin
      if (UNDERRUN_CLR)
        urun_cnt <= UNDERRUN_CNT_W'(1);
      else if (urun_cnt != '1)
        urun_cnt <= urun_cnt + UNDERRUN_CNT_W'(1);
    end else if (UNDERRUN_CLR)
      urun_cnt <= '0;
  end

  assign UNDERRUN_COUNT = urun_cnt;
`else
  assign UNDERRUN_COUNT = '0;
`endif

endmodule

// File: tb/tb_dso100fb_video_timing.sv
// Directed bench for dso100fb_video_timing; expected waveforms derived from the test geometry.
module tb_dso100fb_video_timing;

  localparam int CNT_W = 12;
`ifdef DSO100FB_UNDERRUN_COUNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic             VIDCLK, RST, CFG_ENABLE;
  logic [CNT_W-1:0] CFG_HACTIVE, CFG_HFP, CFG_HSYNC, CFG_HBP;
  logic [CNT_W-1:0] CFG_VACTIVE, CFG_VFP, CFG_VSYNC, CFG_VBP;
  logic             CFG_HSYNC_POL, CFG_VSYNC_POL, CFG_OVL_ENABLE;
  logic [CNT_W-1:0] CFG_OVL_X0, CFG_OVL_X1, CFG_OVL_Y0, CFG_OVL_Y1;
  logic             VIDEO_EMPTY, UNDERRUN_CLR;
  logic             VIDEO_FETCH, OVERLAY_EN, DE, HSYNC, VSYNC, FRAME_START, UNDERRUN;
  logic [15:0]      UNDERRUN_COUNT;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  dso100fb_video_timing #(.CNT_W(CNT_W)) dut (
    .VIDCLK(VIDCLK), .RST(RST), .CFG_ENABLE(CFG_ENABLE),
    .CFG_HACTIVE(CFG_HACTIVE), .CFG_HFP(CFG_HFP), .CFG_HSYNC(CFG_HSYNC), .CFG_HBP(CFG_HBP),
    .CFG_VACTIVE(CFG_VACTIVE), .CFG_VFP(CFG_VFP), .CFG_VSYNC(CFG_VSYNC), .CFG_VBP(CFG_VBP),
    .CFG_HSYNC_POL(CFG_HSYNC_POL), .CFG_VSYNC_POL(CFG_VSYNC_POL),
    .CFG_OVL_ENABLE(CFG_OVL_ENABLE),
    .CFG_OVL_X0(CFG_OVL_X0), .CFG_OVL_X1(CFG_OVL_X1),
    .CFG_OVL_Y0(CFG_OVL_Y0), .CFG_OVL_Y1(CFG_OVL_Y1),
    .VIDEO_EMPTY(VIDEO_EMPTY), .UNDERRUN_CLR(UNDERRUN_CLR),
    .VIDEO_FETCH(VIDEO_FETCH), .OVERLAY_EN(OVERLAY_EN), .DE(DE),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .FRAME_START(FRAME_START),
    .UNDERRUN(UNDERRUN), .UNDERRUN_COUNT(UNDERRUN_COUNT)
  );

  initial begin
    VIDCLK = 1'b0;
    forever #5 VIDCLK = ~VIDCLK;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Cycle c is the interval after the c-th enabled edge; sampled 1 time unit after the edge.
  task automatic step();
    @(posedge VIDCLK);
    #1;
    cyc++;
  endtask

  task automatic restart();
    CFG_ENABLE = 1'b0;
    step();
    step();
    CFG_ENABLE = 1'b1;
    cyc = 0;
  endtask

  task automatic set_default();
    CFG_HACTIVE = 4; CFG_HFP = 1; CFG_HSYNC = 2; CFG_HBP = 1;
    CFG_VACTIVE = 3; CFG_VFP = 1; CFG_VSYNC = 1; CFG_VBP = 1;
    CFG_HSYNC_POL = 1'b1; CFG_VSYNC_POL = 1'b1; CFG_OVL_ENABLE = 1'b0;
    CFG_OVL_X0 = 0; CFG_OVL_X1 = 0; CFG_OVL_Y0 = 0; CFG_OVL_Y1 = 0;
    VIDEO_EMPTY = 1'b0; UNDERRUN_CLR = 1'b0;
  endtask

  // Fetch for raster position p of a frame ht pixels by vt lines with ha x va active.
  function automatic logic fetch_at(int p, int ht, int ha, int vt, int va);
    if (p < 0) return 1'b0;
    return ((p % ht) < ha) && (((p / ht) % vt) < va);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_val({tag, " fetch"}, VIDEO_FETCH, 0);
    check_val({tag, " ovl"},   OVERLAY_EN, 0);
    check_val({tag, " de"},    DE, 0);
    check_val({tag, " hsync"}, HSYNC, 0);
    check_val({tag, " vsync"}, VSYNC, 0);
    check_val({tag, " fs"},    FRAME_START, 0);
    check_val({tag, " urun"},  UNDERRUN, 0);
    check_val({tag, " ucnt"},  UNDERRUN_COUNT, 0);
  endtask

  initial begin
    int p;
    set_default();
    CFG_ENABLE = 1'b0;
    RST = 1'b1;
    step();
    step();
    check_reset_outputs("reset");
    RST = 1'b0;

    // 1: basic raster, htotal 8, vtotal 6
    restart();
    for (int c = 1; c <= 50; c++) begin
      step();
      p = c - 1;
      check_val($sformatf("t1 fetch c%0d", c), VIDEO_FETCH, fetch_at(p, 8, 4, 6, 3));
      check_val($sformatf("t1 de c%0d", c), DE, fetch_at(p - 1, 8, 4, 6, 3));
      check_val($sformatf("t1 hsync c%0d", c), HSYNC,
                (p >= 1) && (((p - 1) % 8 == 5) || ((p - 1) % 8 == 6)));
      check_val($sformatf("t1 vsync c%0d", c), VSYNC, (p >= 1) && (((p - 1) / 8) % 6 == 4));
      check_val($sformatf("t1 fs c%0d", c), FRAME_START, (p % 48) == 0);
      check_val($sformatf("t1 ovl c%0d", c), OVERLAY_EN, 0);
    end

    // 2: overlay window X [1,3), Y [1,2) -> cycles 10 and 11 only
    CFG_OVL_ENABLE = 1'b1;
    CFG_OVL_X0 = 1; CFG_OVL_X1 = 3; CFG_OVL_Y0 = 1; CFG_OVL_Y1 = 2;
    restart();
    for (int c = 1; c <= 48; c++) begin
      step();
      check_val($sformatf("t2 ovl c%0d", c), OVERLAY_EN, (c == 10) || (c == 11));
    end
    CFG_OVL_X1 = 1;
    restart();
    for (int c = 1; c <= 48; c++) begin
      step();
      check_val($sformatf("t2 ovl empty c%0d", c), OVERLAY_EN, 0);
    end

    // 3: HACTIVE 4->6 mid-frame takes effect at the next frame (htotal 10)
    set_default();
    restart();
    for (int c = 1; c <= 110; c++) begin
      step();
      if (c == 10) CFG_HACTIVE = 6;
      if (c <= 48)
        check_val($sformatf("t3 fetch c%0d", c), VIDEO_FETCH, fetch_at(c - 1, 8, 4, 6, 3));
      else
        check_val($sformatf("t3 fetch c%0d", c), VIDEO_FETCH, fetch_at(c - 49, 10, 6, 6, 3));
      check_val($sformatf("t3 fs c%0d", c), FRAME_START, (c == 1) || (c == 49) || (c == 109));
    end

    // 4: underrun over three fetch cycles, then clear, then clear coincident with set
    set_default();
    restart();
    step();
    check_val("t4 urun before", UNDERRUN, 0);
    VIDEO_EMPTY = 1'b1;
    step();
    check_val("t4 urun first", UNDERRUN, 1);
    step();
    step();
    VIDEO_EMPTY = 1'b0;
    check_val("t4 urun after3", UNDERRUN, 1);
    check_val("t4 ucnt after3", UNDERRUN_COUNT, (CNT_EN != 0) ? 3 : 0);
    UNDERRUN_CLR = 1'b1;
    step();
    UNDERRUN_CLR = 1'b0;
    check_val("t4 urun cleared", UNDERRUN, 0);
    check_val("t4 ucnt cleared", UNDERRUN_COUNT, 0);
    while (cyc < 9) step();
    check_val("t4 fetch c9", VIDEO_FETCH, 1);
    VIDEO_EMPTY = 1'b1;
    UNDERRUN_CLR = 1'b1;
    step();
    VIDEO_EMPTY = 1'b0;
    UNDERRUN_CLR = 1'b0;
    check_val("t4 urun set+clr", UNDERRUN, 1);
    check_val("t4 ucnt set+clr", UNDERRUN_COUNT, (CNT_EN != 0) ? 1 : 0);
    step();
    check_val("t4 urun sticky", UNDERRUN, 1);

    // 5: active-low HSYNC, all lengths 0 -> htotal = vtotal = 4
    set_default();
    CFG_HACTIVE = 0; CFG_HFP = 0; CFG_HSYNC = 0; CFG_HBP = 0;
    CFG_VACTIVE = 0; CFG_VFP = 0; CFG_VSYNC = 0; CFG_VBP = 0;
    CFG_HSYNC_POL = 1'b0;
    restart();
    check_val("t5 hsync idle", HSYNC, 1);
    for (int c = 1; c <= 33; c++) begin
      step();
      p = c - 1;
      check_val($sformatf("t5 fetch c%0d", c), VIDEO_FETCH, (p % 16) == 0);
      check_val($sformatf("t5 fs c%0d", c), FRAME_START, (p % 16) == 0);
      check_val($sformatf("t5 hsync c%0d", c), HSYNC, !((p >= 1) && ((p - 1) % 4 == 2)));
      check_val($sformatf("t5 vsync c%0d", c), VSYNC, (p >= 1) && (((p - 1) / 4) % 4 == 2));
    end

    // 6: enable drop at pixel (2,1), re-enable, then RST mid-frame
    set_default();
    restart();
    while (cyc < 11) step();
    check_val("t6 fetch pix2", VIDEO_FETCH, 1);
    CFG_ENABLE = 1'b0;
    step();
    check_val("t6 drop fetch", VIDEO_FETCH, 0);
    check_val("t6 drop de", DE, 1);
    step();
    check_val("t6 idle fetch", VIDEO_FETCH, 0);
    check_val("t6 idle de", DE, 0);
    check_val("t6 idle hsync", HSYNC, 0);
    CFG_ENABLE = 1'b1;
    step();
    check_val("t6 reen fs", FRAME_START, 1);
    check_val("t6 reen fetch", VIDEO_FETCH, 1);
    VIDEO_EMPTY = 1'b1;
    step();
    VIDEO_EMPTY = 1'b0;
    check_val("t6 urun pre-rst", UNDERRUN, 1);
    step();
    RST = 1'b1;
    step();
    check_reset_outputs("t6 rst");
    RST = 1'b0;
    step();
    check_val("t6 post-rst fs", FRAME_START, 1);
    check_val("t6 post-rst fetch", VIDEO_FETCH, 1);
    // Shadows are zero after reset, so pixel 1 is front porch until the next frame boundary.
    step();
    check_val("t6 post-rst h1 fetch", VIDEO_FETCH, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
